hit_judge: RTL and testbench
============================

Name: hit_judge

Overview:
- Sits beside the note scroller. Consumes its judge-column note flags, offset counter and finish strobe, plus the raw red/blue player buttons.
- Decides hit or miss for each note slot and returns a one-cycle delete pulse to the scroller, which clears the hit note.
- Keeps score, hit/note counts and max combo, and latches a grade when the song ends.

Parameters:
- DEBOUNCE_CYCLES, 20'd500000, number of cycles a synchronized button level must stay stable before it is accepted.
- HIT_POINTS, 16'd10, base score added per hit.
- COMBO_BONUS_TH, 8'd10, running combo at or above which a hit scores 2*HIT_POINTS.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- red_btn  input  1  raw red button, asynchronous to clk
- blue_btn  input  1  raw blue button, asynchronous to clk
- note_R_judge  input  1  red note present at judge column
- note_B_judge  input  1  blue note present at judge column
- offset  input  3  scroller pixel counter; counts 0..6; a 6->0 step marks a new note slot
- finish  input  1  high while the song is over
- delete  output  1  one-cycle pulse on a correct hit
- hit_flag  output  1  one-cycle pulse on a correct hit (same cycle as delete)
- miss_flag  output  1  one-cycle pulse on a wrong press or an expired note
- score  output  16  accumulated score, saturating
- max_combo  output  8  longest combo in the current song
- grade  output  2  3=S, 2=A, 1=B, 0=C; valid while finish=1

Behaviour:
- Reset: every output is 0. FSM resets to WAIT. Internal combo, hit_cnt, note_cnt, offset_d and finish_d reset to 0.
- Input conditioning, per button:
  - 2-flop synchronizer, then a debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A rising edge of the accepted level gives a 1-cycle press pulse (press_r or press_b).
  - Press pulse latency: 2 + DEBOUNCE_CYCLES cycles after the raw edge. A held button gives exactly one pulse.
- Slot boundary: slot = (offset_d==3'd6 && offset==3'd0), where offset_d is offset registered one cycle.
- FSM states: WAIT, ARMED, DONE.
  - Any state, on slot with finish=0: if note_R_judge|note_B_judge, go to ARMED, latch exp_color (red if note_R_judge), note_cnt+1. Otherwise go to WAIT.
  - On slot, if the old state was ARMED: miss_flag=1 and combo<=0 in that same cycle, before the new slot is evaluated.
  - ARMED with a matching press, same-colour press only:
    - Registered delete=1 and hit_flag=1 for one cycle; go to DONE.
    - combo<=sat255(combo+1); hit_cnt+1.
    - score <= sat(score + (combo>=COMBO_BONUS_TH ? 2*HIT_POINTS : HIT_POINTS)), comparing the pre-increment combo.
    - max_combo <= max(max_combo, new combo).
  - ARMED with a wrong colour, or both presses in the same cycle: miss_flag=1, combo<=0, go to DONE, no delete.
  - Press and slot in the same cycle: the slot rule wins and the press is dropped. The old note counts as expired.
  - WAIT or DONE: presses are ignored, with no flags and no combo change.
- Finish:
  - While finish=1, the FSM is forced to WAIT and presses are ignored. score, max_combo and counters freeze.
  - On the finish 0->1 edge, grade is latched from hit_cnt (h) and note_cnt (n):
    - n==0 gives 0.
    - 10h >= 9n gives 3.
    - 10h >= 7n gives 2.
    - 10h >= 5n gives 1.
    - Otherwise 0.
    - Products are computed at 14 bits.
  - On the finish 1->0 edge: score, max_combo, combo, hit_cnt, note_cnt and grade clear to 0.
- Counter widths: hit_cnt and note_cnt are 10-bit and saturate at 1023. score saturates at 16'hFFFF.
- Reset mid-song: everything returns to reset values immediately and any in-flight delete pulse is dropped.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4.
- Red note at a slot, red press 3 cycles later -> delete=1 and hit_flag=1 for exactly 1 cycle; score=10; max_combo=1.
- Blue note armed, red press -> miss_flag pulse, no delete, combo=0; a following red press in the same slot is ignored.
- Note armed, no press until next slot -> miss_flag on the boundary cycle; note_cnt=2 if the next slot also holds a note.
- 12 consecutive correct hits -> hits 1-10 add 10 and hits 11-12 add 20 (combo 10 and 11 before those hits); score=140; max_combo=12.
- 9 hits out of 10 notes, then finish rises -> grade=3; 7/10 -> 2; 4/10 -> 0; finish falls -> score, max_combo and grade read 0.
- Raw red glitch shorter than 4 cycles -> no press; rst asserted during a delete pulse -> delete=0 in the same cycle, all outputs 0.

Source files
------------

// File: rtl/hit_judge.sv
// hit_judge: debounces player buttons, judges hits/misses per note slot,
// keeps score, combo and counts, and latches a grade when the song ends.
module hit_judge #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [15:0] HIT_POINTS      = 16'd10,
    parameter logic [7:0]  COMBO_BONUS_TH  = 8'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        red_btn,
    input  logic        blue_btn,
    input  logic        note_R_judge,
    input  logic        note_B_judge,
    input  logic [2:0]  offset,
    input  logic        finish,
    output logic        delete,
    output logic        hit_flag,
    output logic        miss_flag,
    output logic [15:0] score,
    output logic [7:0]  max_combo,
    output logic [1:0]  grade
);
    typedef enum logic [1:0] {WAIT, ARMED, DONE} state_t;
    state_t state, state_nx;
    logic [1:0]  raw, s1, s2, lvl, press;
    logic [19:0] cnt [2];
    logic        pr, pb, slot, hit, miss, new_note, exp_red, finish_d;
    logic [2:0]  offset_d;
    logic [7:0]  combo, combo_inc;
    logic [9:0]  hit_cnt, note_cnt;
    logic [15:0] pts;
    logic [16:0] sum;
    logic [13:0] h10, n9, n7, n5;
    logic [1:0]  grade_nx;

    assign raw = {blue_btn, red_btn};
    assign pr  = press[0];
    assign pb  = press[1];

    // Index 0 is red, 1 is blue; a press pulses when a new high level is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            lvl   <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= '0;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == lvl[i]) cnt[i] <= '0;
                else if (cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    cnt[i]   <= '0;
                    lvl[i]   <= s2[i];
                    press[i] <= s2[i];
                end else cnt[i] <= cnt[i] + 20'd1;
            end
        end
    end

    assign slot = (offset_d == 3'd6) && (offset == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT;
        else     state <= state_nx;
    end

    // A slot boundary overrides any press in the same cycle
    always_comb begin
        state_nx = state;
        hit      = 1'b0;
        miss     = 1'b0;
        new_note = 1'b0;
        if (finish) state_nx = WAIT;
        else if (slot) begin
            miss     = (state == ARMED);
            new_note = note_R_judge | note_B_judge;
            state_nx = new_note ? ARMED : WAIT;
        end else if (state == ARMED && (pr || pb)) begin
            state_nx = DONE;
            hit      = (pr ^ pb) && (pr == exp_red);
            miss     = !hit;
        end
    end

    assign combo_inc = (combo == 8'hFF) ? combo : combo + 8'd1;
    assign pts       = (combo >= COMBO_BONUS_TH) ? {HIT_POINTS[14:0], 1'b0} : HIT_POINTS;
    assign sum       = {1'b0, score} + {1'b0, pts};
    assign h10       = 14'(hit_cnt) * 14'd10;
    assign n9        = 14'(note_cnt) * 14'd9;
    assign n7        = 14'(note_cnt) * 14'd7;
    assign n5        = 14'(note_cnt) * 14'd5;
    assign grade_nx  = (note_cnt == 10'd0) ? 2'd0 :
                       (h10 >= n9) ? 2'd3 :
                       (h10 >= n7) ? 2'd2 :
                       (h10 >= n5) ? 2'd1 : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_d  <= '0;
            finish_d  <= 1'b0;
            delete    <= 1'b0;
            hit_flag  <= 1'b0;
            miss_flag <= 1'b0;
            exp_red   <= 1'b0;
            combo     <= '0;
            hit_cnt   <= '0;
            note_cnt  <= '0;
            score     <= '0;
            max_combo <= '0;
            grade     <= '0;
        end else begin
            offset_d  <= offset;
            finish_d  <= finish;
            delete    <= hit;
            hit_flag  <= hit;
            miss_flag <= miss;
            if (new_note) begin
                exp_red  <= note_R_judge;
                note_cnt <= note_cnt + {9'd0, note_cnt != 10'h3FF};
            end
            if (miss) combo <= '0;
            if (hit) begin
                combo   <= combo_inc;
                hit_cnt <= hit_cnt + {9'd0, hit_cnt != 10'h3FF};
                score   <= sum[16] ? 16'hFFFF : sum[15:0];
                if (combo_inc > max_combo) max_combo <= combo_inc;
            end
            if (finish && !finish_d) grade <= grade_nx;
            if (!finish && finish_d) begin
                combo     <= '0;
                hit_cnt   <= '0;
                note_cnt  <= '0;
                score     <= '0;
                max_combo <= '0;
                grade     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed checks of hit/miss judging, scoring, combo bonus,
// grading, debounce glitch rejection and asynchronous reset.
module tb_hit_judge;
    logic        clk = 0, rst = 1;
    logic        red_btn = 0, blue_btn = 0, note_R_judge = 0, note_B_judge = 0, finish = 0;
    logic [2:0]  offset = 0;
    logic        delete, hit_flag, miss_flag;
    logic [15:0] score;
    logic [7:0]  max_combo;
    logic [1:0]  grade;
    int vectors = 0, miscompares = 0;
    int dcnt, hcnt, mcnt;
    logic found;

    hit_judge #(.DEBOUNCE_CYCLES(20'd4), .HIT_POINTS(16'd10), .COMBO_BONUS_TH(8'd10)) dut (
        .clk(clk), .rst(rst), .red_btn(red_btn), .blue_btn(blue_btn),
        .note_R_judge(note_R_judge), .note_B_judge(note_B_judge), .offset(offset),
        .finish(finish), .delete(delete), .hit_flag(hit_flag), .miss_flag(miss_flag),
        .score(score), .max_combo(max_combo), .grade(grade)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            dcnt += int'(delete);
            hcnt += int'(hit_flag);
            mcnt += int'(miss_flag);
        end
    endtask

    // Present a note and step offset 6 -> 0 so the judge sees a slot boundary
    task automatic do_slot(input logic r, input logic b);
        note_R_judge = r;
        note_B_judge = b;
        offset = 3'd6;
        tick();
        offset = 3'd0;
        tick();
    endtask

    task automatic press(input logic r, input logic b);
        dcnt = 0; hcnt = 0; mcnt = 0;
        red_btn = r; blue_btn = b;
        run(10);
        red_btn = 0; blue_btn = 0;
        run(10);
    endtask

    task automatic song(input int hits, input logic [1:0] exp_grade, input string tag);
        for (int i = 0; i < 10; i++) begin
            do_slot(1, 0);
            if (i < hits) press(1, 0);
            else run(4);
        end
        finish = 1;
        run(3);
        check(tag, grade, exp_grade);
        finish = 0;
        run(3);
    endtask

    initial begin
        repeat (3) tick();
        check("reset_delete", delete, 0);
        check("reset_hit", hit_flag, 0);
        check("reset_miss", miss_flag, 0);
        check("reset_score", score, 0);
        check("reset_max_combo", max_combo, 0);
        check("reset_grade", grade, 0);
        rst = 0;
        tick();

        do_slot(1, 0);
        @(negedge clk);
        check("first_slot_no_miss", miss_flag, 0);
        press(1, 0);
        check("red_hit_delete_pulses", dcnt, 1);
        check("red_hit_flag_pulses", hcnt, 1);
        check("red_hit_no_miss", mcnt, 0);
        check("red_hit_score", score, 10);
        check("red_hit_max_combo", max_combo, 1);

        do_slot(0, 1);
        @(negedge clk);
        check("slot_after_done_no_miss", miss_flag, 0);
        press(1, 0);
        check("wrong_color_miss", mcnt, 1);
        check("wrong_color_no_delete", dcnt, 0);
        check("wrong_color_score", score, 10);
        press(1, 0);
        check("done_press_no_miss", mcnt, 0);
        check("done_press_no_delete", dcnt, 0);

        do_slot(1, 0);
        run(4);
        do_slot(1, 0);
        @(negedge clk);
        check("expired_note_miss", miss_flag, 1);
        press(1, 0);
        check("after_expire_hit", dcnt, 1);
        check("after_expire_score", score, 20);
        check("after_expire_max_combo", max_combo, 1);

        // 2 hits out of 4 notes: 20 >= 20 but < 28
        finish = 1;
        run(3);
        check("grade_2_of_4", grade, 1);
        finish = 0;
        run(3);
        check("clear_score", score, 0);
        check("clear_max_combo", max_combo, 0);
        check("clear_grade", grade, 0);

        for (int i = 0; i < 12; i++) begin
            do_slot(i[0] ? 1'b0 : 1'b1, i[0]);
            press(i[0] ? 1'b0 : 1'b1, i[0]);
            if (i == 9) check("score_after_10", score, 100);
        end
        check("combo_score_140", score, 140);
        check("combo_max_12", max_combo, 12);
        finish = 1;
        run(3);
        check("grade_12_of_12", grade, 3);
        finish = 0;
        run(3);

        song(9, 2'd3, "grade_9_of_10");
        song(7, 2'd2, "grade_7_of_10");
        song(4, 2'd0, "grade_4_of_10");
        check("final_clear_score", score, 0);
        check("final_clear_max_combo", max_combo, 0);
        check("final_clear_grade", grade, 0);

        do_slot(1, 0);
        dcnt = 0; mcnt = 0;
        @(negedge clk);
        red_btn = 1;
        run(3);
        red_btn = 0;
        run(15);
        check("glitch_no_delete", dcnt, 0);
        check("glitch_no_miss", mcnt, 0);

        red_btn = 1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (delete) found = 1;
        end
        check("delete_seen_before_reset", found, 1);
        check("score_before_reset", score, 10);
        rst = 1;
        #1;
        check("reset_drops_delete", delete, 0);
        check("reset_drops_hit", hit_flag, 0);
        check("reset_clears_score", score, 0);
        check("reset_clears_max_combo", max_combo, 0);
        red_btn = 0;
        tick();
        rst = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
